// File: rtl/phase_sequencer.sv
// phase_sequencer: power-up style sequencer that holds a bank of downstream
// phase modules in reset, waits INIT_CYCLES, then releases them one at a time.
// Each phase either lasts a fixed number of cycles (timed) or waits for its
// completion strobe (handshake, bounded by TIMEOUT).
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        begin/restart request (accepted in IDLE or DONE)
//   abort        return to IDLE from any state; wins over everything else
//   phase_len    per-phase cycle length, field i = [i*CNT_W +: CNT_W]
//   phase_mode   per-phase mode, 0 = timed, 1 = handshake
//   phase_done   per-phase completion strobe
//   phase_rst    per-phase reset hold (1 = held in reset)
//   cur_phase    index of the active phase
//   busy         high in INIT or RUN
//   all_done     high in DONE
//   error        high in ERROR (handshake timeout)
module phase_sequencer #(
  parameter int unsigned NUM_PHASES  = 3,
  parameter int unsigned CNT_W       = 10,
  parameter int unsigned INIT_CYCLES = 4,
  parameter int unsigned TIMEOUT     = 1000,
  localparam int unsigned PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [NUM_PHASES*CNT_W-1:0] phase_len,
  input  logic [NUM_PHASES-1:0]       phase_mode,
  input  logic [NUM_PHASES-1:0]       phase_done,
  output logic [NUM_PHASES-1:0]       phase_rst,
  output logic [PH_W-1:0]             cur_phase,
  output logic                        busy,
  output logic                        all_done,
  output logic                        error
);

  localparam logic [PH_W-1:0]  LAST_PHASE = PH_W'(NUM_PHASES - 1);
  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_DONE,
    S_ERROR
  } state_e;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [PH_W-1:0]             cur_phase_q, cur_phase_d;
  logic [NUM_PHASES-1:0]       phase_rst_q, phase_rst_d;
  logic                        busy_q, busy_d;
  logic                        all_done_q, all_done_d;
  logic                        error_q, error_d;
  logic [NUM_PHASES*CNT_W-1:0] len_cfg_q, len_cfg_d;
  logic [NUM_PHASES-1:0]       mode_cfg_q, mode_cfg_d;

  logic [CNT_W-1:0] sel_len;
  logic [CNT_W-1:0] sel_last_cnt;
  logic             sel_mode;
  logic             sel_done;
  logic             advance;
  logic             timeout;

  // Cumulative release: phases 0..p enabled, everything above still held.
  function automatic logic [NUM_PHASES-1:0] run_mask(input logic [PH_W-1:0] p);
    logic [NUM_PHASES-1:0] m;
    m = '1;
    for (int i = 0; i < NUM_PHASES; i++) begin
      m[i] = (PH_W'(i) > p);
    end
    return m;
  endfunction

  // Select the latched config and done strobe of the active phase.
  always_comb begin
    sel_len  = '0;
    sel_mode = 1'b0;
    sel_done = 1'b0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (PH_W'(i) == cur_phase_q) begin
        sel_len  = len_cfg_q[i*CNT_W +: CNT_W];
        sel_mode = mode_cfg_q[i];
        sel_done = phase_done[i];
      end
    end
    // A zero length behaves like a length of one.
    sel_last_cnt = (sel_len == '0) ? '0 : (sel_len - CNT_W'(1));
    advance      = sel_mode ? sel_done : (cnt_q == sel_last_cnt);
    // Done arriving on the timeout cycle still counts as done.
    timeout      = sel_mode && !sel_done && (cnt_q == TMO_LAST);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_phase_d = cur_phase_q;
    phase_rst_d = phase_rst_q;
    busy_d      = busy_q;
    all_done_d  = all_done_q;
    error_d     = error_q;
    len_cfg_d   = len_cfg_q;
    mode_cfg_d  = mode_cfg_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_INIT;
          cnt_d       = '0;
          cur_phase_d = '0;
          phase_rst_d = '1;
          busy_d      = 1'b1;
          all_done_d  = 1'b0;
          len_cfg_d   = phase_len;
          mode_cfg_d  = phase_mode;
        end
      end

      S_INIT: begin
        if (cnt_q == INIT_LAST) begin
          state_d     = S_RUN;
          cnt_d       = '0;
          cur_phase_d = '0;
          phase_rst_d = run_mask('0);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RUN: begin
        if (advance) begin
          cnt_d = '0;
          if (cur_phase_q == LAST_PHASE) begin
            state_d     = S_DONE;
            phase_rst_d = '0;
            busy_d      = 1'b0;
            all_done_d  = 1'b1;
          end else begin
            cur_phase_d = cur_phase_q + PH_W'(1);
            phase_rst_d = run_mask(cur_phase_q + PH_W'(1));
          end
        end else if (timeout) begin
          state_d     = S_ERROR;
          cnt_d       = '0;
          phase_rst_d = '1;
          busy_d      = 1'b0;
          error_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_ERROR: begin
        // Held until abort or reset; start is deliberately ignored.
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides whatever the state logic decided this cycle.
    if (abort) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      cur_phase_d = '0;
      phase_rst_d = '1;
      busy_d      = 1'b0;
      all_done_d  = 1'b0;
      error_d     = 1'b0;
      len_cfg_d   = len_cfg_q;
      mode_cfg_d  = mode_cfg_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cur_phase_q <= '0;
      phase_rst_q <= '1;
      busy_q      <= 1'b0;
      all_done_q  <= 1'b0;
      error_q     <= 1'b0;
      len_cfg_q   <= '0;
      mode_cfg_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_phase_q <= cur_phase_d;
      phase_rst_q <= phase_rst_d;
      busy_q      <= busy_d;
      all_done_q  <= all_done_d;
      error_q     <= error_d;
      len_cfg_q   <= len_cfg_d;
      mode_cfg_q  <= mode_cfg_d;
    end
  end

  assign phase_rst = phase_rst_q;
  assign cur_phase = cur_phase_q;
  assign busy      = busy_q;
  assign all_done  = all_done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed scoreboard bench for phase_sequencer
// (NUM_PHASES=3, CNT_W=10, INIT_CYCLES=4, TIMEOUT=16). Each stimulus cycle
// pushes the hand-computed post-edge output expectation; a monitor pops one
// entry after every rising edge and compares it with the DUT outputs.
module tb_phase_sequencer;

  localparam int unsigned NP = 3;
  localparam int unsigned CW = 10;

  logic             clk;
  logic             rst;
  logic             start;
  logic             abort;
  logic [NP*CW-1:0] phase_len;
  logic [NP-1:0]    phase_mode;
  logic [NP-1:0]    phase_done;
  logic [NP-1:0]    phase_rst;
  logic [1:0]       cur_phase;
  logic             busy;
  logic             all_done;
  logic             error;

  phase_sequencer #(
    .NUM_PHASES (NP),
    .CNT_W      (CW),
    .INIT_CYCLES(4),
    .TIMEOUT    (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .phase_len (phase_len),
    .phase_mode(phase_mode),
    .phase_done(phase_done),
    .phase_rst (phase_rst),
    .cur_phase (cur_phase),
    .busy      (busy),
    .all_done  (all_done),
    .error     (error)
  );

  // {phase_rst, cur_phase, busy, all_done, error}
  typedef struct packed {
    logic [2:0] prst;
    logic [1:0] ph;
    logic       busy;
    logic       done;
    logic       err;
  } obs_t;

  typedef struct {
    obs_t v;
    int   id;
  } exp_t;

  localparam obs_t IDLE_O = {3'b111, 2'd0, 3'b000};
  localparam obs_t INIT_O = {3'b111, 2'd0, 3'b100};
  localparam obs_t P0_O   = {3'b110, 2'd0, 3'b100};
  localparam obs_t P1_O   = {3'b100, 2'd1, 3'b100};
  localparam obs_t P2_O   = {3'b000, 2'd2, 3'b100};
  localparam obs_t DONE_O = {3'b000, 2'd2, 3'b010};
  localparam obs_t ERR1_O = {3'b111, 2'd1, 3'b001};

  exp_t exp_q[$];
  exp_t cur_exp;
  int   n_vec   = 0;
  int   n_bad   = 0;
  int   next_id = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input int id, input obs_t e);
    obs_t a;
    a = {phase_rst, cur_phase, busy, all_done, error};
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL vec%0d @%0t: got rst=%b ph=%0d busy=%b done=%b err=%b, want rst=%b ph=%0d busy=%b done=%b err=%b",
               id, $time, a.prst, a.ph, a.busy, a.done, a.err,
               e.prst, e.ph, e.busy, e.done, e.err);
    end
  endtask

  // One clock: drive inputs for this edge and queue the post-edge expectation.
  task automatic cyc(input logic st, input logic ab, input logic [2:0] dn, input obs_t e);
    exp_t x;
    @(negedge clk);
    start      = st;
    abort      = ab;
    phase_done = dn;
    x.v = e;
    x.id = next_id;
    next_id++;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    start      = 1'b0;
    abort      = 1'b0;
    phase_done = '0;
  endtask

  task automatic hold(input int n, input obs_t e);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 3'b000, e);
  endtask

  // Monitor: one expectation per rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        cur_exp = exp_q.pop_front();
        check(cur_exp.id, cur_exp.v);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    phase_done = '0;
    phase_len  = {10'd2, 10'd3, 10'd5};
    phase_mode = 3'b000;

    // Reset values, then idle without start.
    hold(2, IDLE_O);
    #2 rst = 1'b0;
    hold(2, IDLE_O);

    // All timed 5/3/2; inputs scrambled after start must not matter.
    cyc(1'b1, 1'b0, 3'b000, INIT_O);
    phase_len  = '1;
    phase_mode = '1;
    hold(3, INIT_O);
    hold(5, P0_O);
    hold(3, P1_O);
    hold(2, P2_O);
    hold(2, DONE_O);

    // Restart from DONE, phase 1 handshake done at its cycle 7.
    phase_len  = {10'd2, 10'd3, 10'd5};
    phase_mode = 3'b010;
    cyc(1'b1, 1'b0, 3'b000, INIT_O);
    hold(3, INIT_O);
    hold(5, P0_O);
    hold(1, P1_O);
    cyc(1'b0, 1'b0, 3'b100, P1_O);
    cyc(1'b0, 1'b0, 3'b001, P1_O);
    hold(5, P1_O);
    cyc(1'b0, 1'b0, 3'b010, P2_O);
    hold(1, P2_O);
    hold(2, DONE_O);

    // Handshake timeout; start ignored in INIT, RUN and ERROR; abort exits.
    cyc(1'b1, 1'b0, 3'b000, INIT_O);
    cyc(1'b1, 1'b0, 3'b000, INIT_O);
    hold(2, INIT_O);
    hold(2, P0_O);
    cyc(1'b1, 1'b0, 3'b000, P0_O);
    hold(2, P0_O);
    hold(1, P1_O);
    cyc(1'b0, 1'b0, 3'b101, P1_O);
    hold(14, P1_O);
    hold(1, ERR1_O);
    cyc(1'b1, 1'b0, 3'b000, ERR1_O);
    hold(1, ERR1_O);
    cyc(1'b0, 1'b1, 3'b000, IDLE_O);
    hold(1, IDLE_O);

    // Zero lengths: one cycle per phase; abort beats start in DONE.
    phase_len  = '0;
    phase_mode = 3'b000;
    cyc(1'b1, 1'b0, 3'b000, INIT_O);
    hold(3, INIT_O);
    hold(1, P0_O);
    hold(1, P1_O);
    hold(1, P2_O);
    hold(2, DONE_O);
    cyc(1'b1, 1'b1, 3'b000, IDLE_O);
    hold(1, IDLE_O);

    // Abort beats a timed advance, abort out of INIT.
    cyc(1'b1, 1'b0, 3'b000, INIT_O);
    hold(3, INIT_O);
    hold(1, P0_O);
    cyc(1'b0, 1'b1, 3'b000, IDLE_O);
    cyc(1'b1, 1'b0, 3'b000, INIT_O);
    cyc(1'b0, 1'b1, 3'b000, IDLE_O);
    hold(1, IDLE_O);

    // Abort beats a handshake done.
    phase_mode = 3'b010;
    cyc(1'b1, 1'b0, 3'b000, INIT_O);
    hold(3, INIT_O);
    hold(1, P0_O);
    hold(1, P1_O);
    cyc(1'b0, 1'b1, 3'b010, IDLE_O);
    hold(1, IDLE_O);

    // Reset mid phase 1, then start+abort, then a fresh run with new lengths.
    phase_len  = {10'd2, 10'd3, 10'd5};
    phase_mode = 3'b000;
    cyc(1'b1, 1'b0, 3'b000, INIT_O);
    hold(3, INIT_O);
    hold(5, P0_O);
    hold(2, P1_O);
    #2 rst = 1'b1;
    #1 check(next_id, IDLE_O);
    next_id++;
    hold(2, IDLE_O);
    #2 rst = 1'b0;
    phase_len = {10'd1, 10'd1, 10'd2};
    cyc(1'b1, 1'b1, 3'b000, IDLE_O);
    hold(1, IDLE_O);
    cyc(1'b1, 1'b0, 3'b000, INIT_O);
    hold(3, INIT_O);
    hold(2, P0_O);
    hold(1, P1_O);
    hold(1, P2_O);
    hold(1, DONE_O);

    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
